mem_wb_ctrl: RTL and testbench

MEM_WB_CTRL -- requirements
Module: mem_wb_ctrl

---
 rtl/mem_wb_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_wb_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_ctrl.sv
// MEM/WB stage controller: issues data-memory accesses for loads/stores, stalls EX while
// an access is outstanding, and registers the writeback fields for the register file.
module mem_wb_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        ex_rmem_i,
  input  logic        ex_wmem_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_rn_i,
  input  logic [31:0] ex_alu_i,
  input  logic [31:0] ex_sd_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_rn_o,
  output logic [31:0] wb_r_o,
  output logic [31:0] wb_di_o,
  output logic        wb_m2reg_o,
  output logic        err_o
);

  typedef enum logic {StIdle, StAccess} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rn_q, wb_rn_d;
  logic [31:0] wb_r_q, wb_r_d;
  logic [31:0] wb_di_q, wb_di_d;
  logic        wb_m2reg_q, wb_m2reg_d;
  logic        err_q, err_d;
  logic        stall;

  logic mem_op, aligned, issue, cnt_last;

  assign mem_op   = ex_rmem_i | ex_wmem_i;
  assign aligned  = (ex_alu_i[1:0] == 2'b00);
  assign issue    = ex_valid_i & mem_op & aligned;
  assign cnt_last = (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and access counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (issue) state_d = StAccess;
      end
      StAccess: begin
        if (mem_ack_i || cnt_last) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and registered memory/writeback fields
  always_comb begin
    stall       = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_we_d     = wb_we_q;
    wb_rn_d     = wb_rn_q;
    wb_r_d      = wb_r_q;
    wb_di_d     = wb_di_q;
    wb_m2reg_d  = wb_m2reg_q;
    unique case (state_q)
      StIdle: begin
        if (!ex_valid_i) begin
          wb_we_d = 1'b0;
        end else if (!mem_op) begin
          wb_we_d    = ex_wreg_i;
          wb_rn_d    = ex_rn_i;
          wb_r_d     = ex_alu_i;
          wb_m2reg_d = 1'b0;
        end else if (!aligned) begin
          wb_we_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          stall       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = ex_wmem_i;
          mem_addr_d  = ex_alu_i;
          mem_wdata_d = ex_sd_i;
          wb_we_d     = 1'b0;
        end
      end
      StAccess: begin
        wb_we_d = 1'b0;
        // Ack takes priority over the timeout in the same cycle
        if (mem_ack_i) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_di_d    = mem_rdata_i;
          wb_r_d     = mem_addr_q;
          wb_rn_d    = ex_rn_i;
          wb_we_d    = ~mem_we_q & ex_wreg_i;
          wb_m2reg_d = ~mem_we_q;
        end else if (cnt_last) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_we_q     <= 1'b0;
      wb_rn_q     <= '0;
      wb_r_q      <= '0;
      wb_di_q     <= '0;
      wb_m2reg_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_we_q     <= wb_we_d;
      wb_rn_q     <= wb_rn_d;
      wb_r_q      <= wb_r_d;
      wb_di_q     <= wb_di_d;
      wb_m2reg_q  <= wb_m2reg_d;
      err_q       <= err_d;
    end
  end

  // Stall is combinational, so it is masked directly while reset is held
  assign stall_o     = stall & ~rst_i;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_we_o     = wb_we_q;
  assign wb_rn_o     = wb_rn_q;
  assign wb_r_o      = wb_r_q;
  assign wb_di_o     = wb_di_q;
  assign wb_m2reg_o  = wb_m2reg_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Self-checking bench for mem_wb_ctrl: directed scenarios plus randomized ops checked
// against a transaction-level model of the writeback registers.
module tb_mem_wb_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_rmem = 1'b0, ex_wmem = 1'b0, ex_wreg = 1'b0;
  logic [4:0]  ex_rn = '0;
  logic [31:0] ex_alu = '0, ex_sd = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_o, mem_req_o, mem_we_o, wb_we_o, wb_m2reg_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, wb_r_o, wb_di_o;
  logic [4:0]  wb_rn_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit junk_ack = 1'b0;

  // Model of the writeback registers
  logic        m_we = 1'b0, m_m2reg = 1'b0;
  logic [4:0]  m_rn = '0;
  logic [31:0] m_r = '0, m_di = '0;
  // Expected per-op observations
  int e_stall, e_req, e_err;

  mem_wb_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_rmem_i(ex_rmem),
    .ex_wmem_i(ex_wmem), .ex_wreg_i(ex_wreg), .ex_rn_i(ex_rn), .ex_alu_i(ex_alu),
    .ex_sd_i(ex_sd), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
    .mem_ack_i(mem_ack), .wb_we_o(wb_we_o), .wb_rn_o(wb_rn_o), .wb_r_o(wb_r_o),
    .wb_di_o(wb_di_o), .wb_m2reg_o(wb_m2reg_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Spec-level outcome of one instruction; ack_at is the ACCESS cycle index of the ack (-1: none)
  task automatic model_op(input logic valid, rmem, wmem, wreg, input logic [4:0] rn,
                          input logic [31:0] alu, rdata, input int ack_at);
    e_stall = 0; e_req = 0; e_err = 0;
    if (!valid) begin
      m_we = 1'b0;
    end else if (!rmem && !wmem) begin
      m_we = wreg; m_rn = rn; m_r = alu; m_m2reg = 1'b0;
    end else if (alu % 4 != 0) begin
      m_we = 1'b0; e_err = 1;
    end else if (ack_at >= 0 && ack_at < int'(TO)) begin
      e_stall = 1 + ack_at; e_req = ack_at + 1;
      m_di = rdata; m_r = alu; m_rn = rn;
      m_we = rmem ? wreg : 1'b0;
      m_m2reg = rmem;
    end else begin
      e_stall = TO; e_req = TO; e_err = 1; m_we = 1'b0;
    end
  endtask

  // Presents one instruction, plays memory, and reports what was seen until it leaves EX
  task automatic run_op(input logic valid, rmem, wmem, wreg, input logic [4:0] rn,
                        input logic [31:0] alu, sd, rdata, input int ack_at,
                        output int stall_n, req_n, err_n, output bit bus_ok, finished);
    int acc;
    bit done;
    stall_n = 0; req_n = 0; err_n = 0; bus_ok = 1'b1; acc = 0; done = 1'b0;
    ex_valid = valid; ex_rmem = rmem; ex_wmem = wmem; ex_wreg = wreg;
    ex_rn = rn; ex_alu = alu; ex_sd = sd; mem_rdata = rdata;
    for (int n = 0; n < 64 && !done; n++) begin
      if (mem_req_o) begin
        req_n++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {wmem, alu, sd}) bus_ok = 1'b0;
        mem_ack = (acc == ack_at);
        acc++;
      end else begin
        mem_ack = junk_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      if (stall_o) stall_n++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (err_o) err_n++;
    end
    finished = done;
    mem_ack = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    ex_valid = 1'b1; ex_rmem = 1'b1; ex_alu = 32'h40; mem_ack = 1'b1;
    #1;
    checks++;
    if ({stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wb_we_o, wb_rn_o, wb_r_o,
         wb_di_o, wb_m2reg_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b wb_we=%b err=%b, all required 0",
               stall_o, mem_req_o, mem_we_o, wb_we_o, err_o);
    end
    cycle(); cycle();
    checks++;
    if ({stall_o, mem_req_o, wb_we_o, err_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_held: stall=%b req=%b wb_we=%b err=%b, required 0",
               stall_o, mem_req_o, wb_we_o, err_o);
    end
    ex_valid = 1'b0; ex_rmem = 1'b0; mem_ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int s, r, e; bit ok, fin;
    run_op(1, 0, 0, 1, 5'd3, 32'h5, 32'h0, 32'h0, -1, s, r, e, ok, fin);
    model_op(1, 0, 0, 1, 5'd3, 32'h5, 32'h0, -1);
    checks++;
    if ({s, wb_we_o, wb_rn_o, wb_r_o, wb_m2reg_o} !== {32'd0, 1'b1, 5'd3, 32'h5, 1'b0}) begin
      errors++;
      $display("FAIL add: stall=%0d we=%b rn=%0d r=%h m2reg=%b, required 0 1 3 5 0",
               s, wb_we_o, wb_rn_o, wb_r_o, wb_m2reg_o);
    end
  endtask

  task automatic test_lw();
    int s, r, e; bit ok, fin;
    run_op(1, 1, 0, 1, 5'd7, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, s, r, e, ok, fin);
    model_op(1, 1, 0, 1, 5'd7, 32'h10, 32'hDEAD_BEEF, 2);
    checks++;
    if (s != 3 || r != 3 || e != 0 || !ok) begin
      errors++;
      $display("FAIL lw_timing: stall=%0d req=%0d err=%0d bus_ok=%0d, required 3 3 0 1",
               s, r, e, ok);
    end
    checks++;
    if ({wb_we_o, wb_m2reg_o, wb_di_o, wb_r_o, wb_rn_o} !==
        {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd7}) begin
      errors++;
      $display("FAIL lw_wb: we=%b m2reg=%b di=%h r=%h rn=%0d, required 1 1 deadbeef 10 7",
               wb_we_o, wb_m2reg_o, wb_di_o, wb_r_o, wb_rn_o);
    end
  endtask

  task automatic test_sw();
    int s, r, e; bit ok, fin;
    run_op(1, 0, 1, 1, 5'd9, 32'h20, 32'h1234_5678, 32'h0BAD_F00D, 0, s, r, e, ok, fin);
    model_op(1, 0, 1, 1, 5'd9, 32'h20, 32'h0BAD_F00D, 0);
    checks++;
    if (s != 1 || r != 1 || e != 0 || !ok || mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL sw_bus: stall=%0d req=%0d err=%0d bus_ok=%0d we_after=%b, required 1 1 0 1 0",
               s, r, e, ok, mem_we_o);
    end
    checks++;
    if ({wb_we_o, wb_m2reg_o} !== 2'b00) begin
      errors++;
      $display("FAIL sw_wb: we=%b m2reg=%b, required 0 0", wb_we_o, wb_m2reg_o);
    end
  endtask

  task automatic test_misaligned();
    int s, r, e; bit ok, fin;
    run_op(1, 1, 0, 1, 5'd4, 32'h13, 32'h0, 32'h0, 0, s, r, e, ok, fin);
    model_op(1, 1, 0, 1, 5'd4, 32'h13, 32'h0, 0);
    checks++;
    if (s != 0 || r != 0 || e != 1 || wb_we_o !== 1'b0) begin
      errors++;
      $display("FAIL misaligned: stall=%0d req=%0d err=%0d wb_we=%b, required 0 0 1 0",
               s, r, e, wb_we_o);
    end
    cycle();
    model_op(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, -1);
    checks++;
    if (err_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_once: err=%b req=%b, required 0 0", err_o, mem_req_o);
    end
  endtask

  task automatic test_timeout();
    int s, r, e; bit ok, fin;
    run_op(1, 1, 0, 1, 5'd5, 32'h44, 32'h0, 32'h5555_AAAA, -1, s, r, e, ok, fin);
    model_op(1, 1, 0, 1, 5'd5, 32'h44, 32'h5555_AAAA, -1);
    checks++;
    if (r != int'(TO) || s != int'(TO) || e != 1 || !fin) begin
      errors++;
      $display("FAIL timeout: req=%0d stall=%0d err=%0d done=%0d, required %0d %0d 1 1",
               r, s, e, fin, TO, TO);
    end
    checks++;
    if ({wb_we_o, wb_rn_o, wb_r_o, wb_di_o, wb_m2reg_o} !== {m_we, m_rn, m_r, m_di, m_m2reg}) begin
      errors++;
      $display("FAIL timeout_wb: we=%b rn=%0d r=%h di=%h, required %b %0d %h %h",
               wb_we_o, wb_rn_o, wb_r_o, wb_di_o, m_we, m_rn, m_r, m_di);
    end
    run_op(1, 1, 0, 1, 5'd6, 32'h48, 32'h0, 32'hCAFE_0001, TO - 1, s, r, e, ok, fin);
    model_op(1, 1, 0, 1, 5'd6, 32'h48, 32'hCAFE_0001, TO - 1);
    checks++;
    if (r != int'(TO) || e != 0 || {wb_we_o, wb_di_o} !== {1'b1, 32'hCAFE_0001}) begin
      errors++;
      $display("FAIL timeout_ack: req=%0d err=%0d we=%b di=%h, required %0d 0 1 cafe0001",
               r, e, wb_we_o, wb_di_o, TO);
    end
  endtask

  task automatic test_idle();
    int s, r, e; bit ok, fin;
    junk_ack = 1'b1;
    run_op(1, 0, 0, 1, 5'd12, 32'h77, 32'h0, 32'h0, -1, s, r, e, ok, fin);
    model_op(1, 0, 0, 1, 5'd12, 32'h77, 32'h0, -1);
    run_op(0, 1, 0, 1, 5'd13, 32'h80, 32'h0, 32'h0, 0, s, r, e, ok, fin);
    model_op(0, 1, 0, 1, 5'd13, 32'h80, 32'h0, 0);
    junk_ack = 1'b0;
    checks++;
    if ({wb_we_o, wb_rn_o, wb_r_o, wb_di_o, wb_m2reg_o, mem_req_o} !==
        {m_we, m_rn, m_r, m_di, m_m2reg, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: we=%b rn=%0d r=%h req=%b, required %b %0d %h 0",
               wb_we_o, wb_rn_o, wb_r_o, mem_req_o, m_we, m_rn, m_r);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2, r, e; bit ok, fin; int c0;
    c0 = cyc;
    run_op(1, 1, 0, 1, 5'd1, 32'h100, 32'h0, 32'h1111_1111, 0, s1, r, e, ok, fin);
    model_op(1, 1, 0, 1, 5'd1, 32'h100, 32'h1111_1111, 0);
    run_op(1, 1, 0, 1, 5'd2, 32'h104, 32'h0, 32'h2222_2222, 0, s2, r, e, ok, fin);
    model_op(1, 1, 0, 1, 5'd2, 32'h104, 32'h2222_2222, 0);
    checks++;
    if (cyc - c0 != 4 || s1 != 1 || s2 != 1) begin
      errors++;
      $display("FAIL back_to_back: cycles=%0d stalls=%0d/%0d, required 4 1/1", cyc - c0, s1, s2);
    end
    checks++;
    if ({wb_we_o, wb_rn_o, wb_di_o, wb_r_o} !== {1'b1, 5'd2, 32'h2222_2222, 32'h104}) begin
      errors++;
      $display("FAIL back_to_back_wb: we=%b rn=%0d di=%h r=%h, required 1 2 22222222 104",
               wb_we_o, wb_rn_o, wb_di_o, wb_r_o);
    end
  endtask

  task automatic test_reset_mid_access();
    int s, r, e; bit ok, fin;
    ex_valid = 1'b1; ex_rmem = 1'b1; ex_wmem = 1'b0; ex_wreg = 1'b1;
    ex_rn = 5'd8; ex_alu = 32'h200; mem_ack = 1'b0;
    cycle(); cycle();
    checks++;
    if ({mem_req_o, stall_o} !== 2'b11) begin
      errors++;
      $display("FAIL mid_access_pre: req=%b stall=%b, required 1 1", mem_req_o, stall_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({stall_o, mem_req_o, mem_we_o, mem_addr_o, wb_we_o, wb_r_o, wb_di_o, err_o} !== '0) begin
      errors++;
      $display("FAIL mid_access_reset: stall=%b req=%b addr=%h r=%h, required all 0",
               stall_o, mem_req_o, mem_addr_o, wb_r_o);
    end
    cycle();
    ex_valid = 1'b0;
    rst = 1'b0;
    m_we = 1'b0; m_rn = '0; m_r = '0; m_di = '0; m_m2reg = 1'b0;
    run_op(1, 1, 0, 1, 5'd10, 32'h300, 32'h0, 32'h3333_4444, 1, s, r, e, ok, fin);
    model_op(1, 1, 0, 1, 5'd10, 32'h300, 32'h3333_4444, 1);
    checks++;
    if (s != 2 || e != 0 || !ok ||
        {wb_we_o, wb_m2reg_o, wb_rn_o, wb_di_o} !== {1'b1, 1'b1, 5'd10, 32'h3333_4444}) begin
      errors++;
      $display("FAIL after_reset_lw: stall=%0d err=%0d bus_ok=%0d we=%b di=%h, required 2 0 1 1 33334444",
               s, e, ok, wb_we_o, wb_di_o);
    end
  endtask

  task automatic test_random();
    int s, r, e; bit ok, fin;
    logic valid, rmem, wmem, wreg;
    logic [4:0] rn;
    logic [31:0] alu, sd, rdata;
    int kind, ack_at;
    junk_ack = 1'b1;
    for (int i = 0; i < 200; i++) begin
      kind  = int'($urandom_range(0, 9));
      valid = (kind != 0);
      rmem  = (kind >= 2 && kind <= 5);
      wmem  = (kind >= 6 && kind <= 8);
      wreg  = 1'($urandom_range(0, 1));
      rn    = 5'($urandom);
      alu   = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      sd     = $urandom;
      rdata  = $urandom;
      ack_at = int'($urandom_range(0, TO + 1)) - 1;
      run_op(valid, rmem, wmem, wreg, rn, alu, sd, rdata, ack_at, s, r, e, ok, fin);
      model_op(valid, rmem, wmem, wreg, rn, alu, rdata, ack_at);
      checks++;
      if (s != e_stall || r != e_req || e != e_err || !ok || !fin) begin
        errors++;
        $display("FAIL rand_op[%0d]: stall=%0d req=%0d err=%0d bus_ok=%0d done=%0d, required %0d %0d %0d 1 1",
                 i, s, r, e, ok, fin, e_stall, e_req, e_err);
      end
      checks++;
      if ({wb_we_o, wb_rn_o, wb_r_o, wb_di_o, wb_m2reg_o} !== {m_we, m_rn, m_r, m_di, m_m2reg}) begin
        errors++;
        $display("FAIL rand_wb[%0d]: we=%b rn=%0d r=%h di=%h m2reg=%b, required %b %0d %h %h %b",
                 i, wb_we_o, wb_rn_o, wb_r_o, wb_di_o, wb_m2reg_o, m_we, m_rn, m_r, m_di, m_m2reg);
      end
    end
    junk_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    cycle();
    test_add();
    test_lw();
    test_sw();
    test_misaligned();
    test_timeout();
    test_idle();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
